fetch_ctrl: RTL and testbench

Fetch-stage controller that owns the architectural fetch PC and sequences instruction-bus requests. It resolves redirect sources by priority and tracks one outstanding request, discarding wrong-path responses after flushes. It also buffers one fetched instruction for decode. It sits between the later pipeline stages, which supply redirects, and the instruction bus / decode stage.

---
 rtl/fetch_ctrl.sv | 178 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage controller. Owns the fetch PC, resolves redirects
// (exception > eret > branch > jr > jump), keeps at most one instruction-bus
// request in flight and holds one fetched instruction for decode.
// Optional feature macro: FETCH_ADEL_EN -- a misaligned fetch PC raises an
// address-error entry in the output buffer instead of issuing a bus request.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exception_valid,
  input  logic [31:0] pcexception,
  input  logic        is_eret,
  input  logic [31:0] pc_eret,
  input  logic        branch_taken,
  input  logic [31:0] pcbranch,
  input  logic        is_jr,
  input  logic [31:0] pcjr,
  input  logic        is_jump,
  input  logic [31:0] pcjump,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_adel,
  input  logic        d_ready
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // issuing a request
    S_WAIT = 2'd1,  // one request outstanding, response wanted
    S_DROP = 2'd2   // one request outstanding, response is wrong-path
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ipc_reg;
  logic        f_valid_reg, f_valid_next;
  logic [31:0] f_pc_reg;
  logic [31:0] f_instr_reg;

  logic        flush;
  logic        redirect;
  logic [31:0] target;
  logic        buf_free;
  logic        adel_stall;
  logic        handshake;
  logic        load_resp;
  logic        load_adel;

  // Redirect resolution: flush class clears state, any redirect loads pc.
  always_comb begin
    flush    = exception_valid || is_eret;
    redirect = flush || branch_taken || is_jr || is_jump;
    if (exception_valid)   target = pcexception;
    else if (is_eret)      target = pc_eret;
    else if (branch_taken) target = pcbranch;
    else if (is_jr)        target = pcjr;
    else                   target = pcjump;
  end

  // The buffer can accept a new entry once it is empty or draining this cycle.
  assign buf_free = !f_valid_reg || d_ready;

`ifdef FETCH_ADEL_EN
  assign adel_stall = (pc_reg[1:0] != 2'b00);
`else
  assign adel_stall = 1'b0;
`endif

  // Next-state and request logic for the request/wait/drop sequencer.
  always_comb begin
    state_next = state_reg;
    ireq_valid = 1'b0;
    handshake  = 1'b0;
    load_resp  = 1'b0;
    load_adel  = 1'b0;
    case (state_reg)
      S_REQ: begin
        if (adel_stall) begin
          // Misaligned pc: report the fault through the buffer, no bus traffic.
          load_adel = buf_free && !flush;
        end else begin
          ireq_valid = buf_free;
          if (buf_free && ireq_ready) begin
            handshake  = 1'b1;
            state_next = flush ? S_DROP : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (iresp_valid) begin
          // A flush coinciding with the response discards it.
          load_resp  = !flush;
          state_next = S_REQ;
        end else if (flush) begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (iresp_valid) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase

    if (redirect)       pc_next = target;
    else if (handshake) pc_next = pc_reg + 32'd4;
    else                pc_next = pc_reg;

    if (flush)                        f_valid_next = 1'b0;
    else if (load_resp || load_adel)  f_valid_next = 1'b1;
    else if (d_ready)                 f_valid_next = 1'b0;
    else                              f_valid_next = f_valid_reg;
  end

  assign ireq_addr = pc_reg;

  // State, pc and in-flight request PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_REQ;
      pc_reg    <= RESET_PC;
      ipc_reg   <= 32'h0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (handshake) ipc_reg <= pc_reg;
    end
  end

  // Output buffer: filled by a response or a fetch fault, drained by decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_valid_reg <= 1'b0;
      f_pc_reg    <= 32'h0;
      f_instr_reg <= 32'h0;
    end else begin
      f_valid_reg <= f_valid_next;
      if (load_resp) begin
        f_pc_reg    <= ipc_reg;
        f_instr_reg <= iresp_data;
      end else if (load_adel) begin
        f_pc_reg    <= pc_reg;
        f_instr_reg <= 32'h0;
      end
    end
  end

`ifdef FETCH_ADEL_EN
  logic f_adel_reg;

  // Fault flag travels with the buffered entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_adel_reg <= 1'b0;
    end else if (flush) begin
      f_adel_reg <= 1'b0;
    end else if (load_resp) begin
      f_adel_reg <= 1'b0;
    end else if (load_adel) begin
      f_adel_reg <= 1'b1;
    end
  end

  assign f_adel = f_adel_reg;
`else
  assign f_adel = 1'b0;
`endif

  assign f_valid = f_valid_reg;
  assign f_pc    = f_pc_reg;
  assign f_instr = f_instr_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed, table-driven bench for fetch_ctrl. Each table row
// drives one cycle of inputs and lists the outputs expected before that
// cycle's clock edge. Hand-written sequences cover reset mid-request, pc
// wrap-around and a flush coinciding with a response.
module tb_fetch_ctrl;

`ifdef FETCH_ADEL_EN
  localparam logic A = 1'b1;
`else
  localparam logic A = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        exception_valid, is_eret, branch_taken, is_jr, is_jump;
  logic [31:0] pcexception, pc_eret, pcbranch, pcjr, pcjump;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_adel;
  logic        d_ready;

  int tests;
  int failed;

  fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .exception_valid(exception_valid), .pcexception(pcexception),
    .is_eret(is_eret), .pc_eret(pc_eret),
    .branch_taken(branch_taken), .pcbranch(pcbranch),
    .is_jr(is_jr), .pcjr(pcjr),
    .is_jump(is_jump), .pcjump(pcjump),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_adel(f_adel),
    .d_ready(d_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rmask bits: [4] exception, [3] eret, [2] branch, [1] jr, [0] jump.
  // The highest-priority asserted source gets tgt, all others get alt.
  typedef struct {
    logic [4:0]  rmask;
    logic [31:0] tgt;
    logic [31:0] alt;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        dr;
    logic        e_iv;
    logic [31:0] e_addr;
    logic        e_fv;
    logic [31:0] e_fpc;
    logic [31:0] e_fi;
    logic        e_adel;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t v(logic [4:0] rm, logic [31:0] tg, logic [31:0] al,
                             logic rdy, logic rv, logic [31:0] rd, logic dr,
                             logic eiv, logic [31:0] eaddr, logic efv,
                             logic [31:0] efpc, logic [31:0] efi, logic eadel);
    vec_t r;
    r.rmask = rm; r.tgt = tg; r.alt = al;
    r.rdy = rdy; r.rv = rv; r.rd = rd; r.dr = dr;
    r.e_iv = eiv; r.e_addr = eaddr; r.e_fv = efv;
    r.e_fpc = efpc; r.e_fi = efi; r.e_adel = eadel;
    return r;
  endfunction

  task automatic apply(input vec_t x);
    logic [4:0] m;
    m = x.rmask;
    exception_valid = m[4];
    is_eret         = m[3];
    branch_taken    = m[2];
    is_jr           = m[1];
    is_jump         = m[0];
    pcexception = x.tgt;
    pc_eret     = (m[4]) ? x.alt : x.tgt;
    pcbranch    = (m[4] || m[3]) ? x.alt : x.tgt;
    pcjr        = (m[4] || m[3] || m[2]) ? x.alt : x.tgt;
    pcjump      = (m[4] || m[3] || m[2] || m[1]) ? x.alt : x.tgt;
    ireq_ready  = x.rdy;
    iresp_valid = x.rv;
    iresp_data  = x.rd;
    d_ready     = x.dr;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t x);
    chk({tag, " ireq_valid"}, {31'h0, ireq_valid}, {31'h0, x.e_iv});
    if (x.e_iv) chk({tag, " ireq_addr"}, ireq_addr, x.e_addr);
    chk({tag, " f_valid"}, {31'h0, f_valid}, {31'h0, x.e_fv});
    if (x.e_fv) begin
      chk({tag, " f_pc"}, f_pc, x.e_fpc);
      chk({tag, " f_instr"}, f_instr, x.e_fi);
    end
    chk({tag, " f_adel"}, {31'h0, f_adel}, {31'h0, x.e_adel});
    $display("[TB] %s iv=%0b addr=%h fv=%0b fpc=%h fi=%h adel=%0b",
             tag, ireq_valid, ireq_addr, f_valid, f_pc, f_instr, f_adel);
  endtask

  initial begin
    tests  = 0;
    failed = 0;

    // Sequential fetch, then redirects of every class and corner cases.
    vecs[0]  = v(5'b00000, 0, 0, 1,0,32'h0,1,        1,32'hbfc00000, 0,0,0,0);
    vecs[1]  = v(5'b00000, 0, 0, 1,1,32'h11111111,1, 0,32'hbfc00004, 0,0,0,0);
    vecs[2]  = v(5'b00000, 0, 0, 1,0,32'h0,1,        1,32'hbfc00004, 1,32'hbfc00000,32'h11111111,0);
    vecs[3]  = v(5'b00000, 0, 0, 1,1,32'h22222222,1, 0,32'hbfc00008, 0,0,0,0);
    // exception + branch together during handshake: exception wins, request stale
    vecs[4]  = v(5'b10100, 32'hbfc00380, 32'h80001000, 1,0,32'h0,1,
                 1,32'hbfc00008, 1,32'hbfc00004,32'h22222222,0);
    vecs[5]  = v(5'b00000, 0, 0, 0,1,32'h33333333,1, 0,32'hbfc00380, 0,0,0,0);
    vecs[6]  = v(5'b00000, 0, 0, 1,0,32'h0,1,        1,32'hbfc00380, 0,0,0,0);
    // exception in WAIT, wrong-path response a cycle later
    vecs[7]  = v(5'b10000, 32'h80000180, 0, 0,0,32'h0,1, 0,32'hbfc00384, 0,0,0,0);
    vecs[8]  = v(5'b00000, 0, 0, 0,1,32'hdeadbeef,1, 0,32'h80000180, 0,0,0,0);
    vecs[9]  = v(5'b00000, 0, 0, 1,0,32'h0,1,        1,32'h80000180, 0,0,0,0);
    // branch in the response cycle: delay slot kept
    vecs[10] = v(5'b00100, 32'h80002000, 0, 0,1,32'h44444444,1, 0,32'h80000184, 0,0,0,0);
    // decode stall: no request, buffer held
    vecs[11] = v(5'b00000, 0, 0, 1,0,32'h0,0, 0,32'h80002000, 1,32'h80000180,32'h44444444,0);
    vecs[12] = v(5'b00000, 0, 0, 1,0,32'h0,0, 0,32'h80002000, 1,32'h80000180,32'h44444444,0);
    vecs[13] = v(5'b00000, 0, 0, 1,0,32'h0,1, 1,32'h80002000, 1,32'h80000180,32'h44444444,0);
    vecs[14] = v(5'b00010, 32'h80003000, 0, 0,1,32'h55555555,1, 0,32'h80002004, 0,0,0,0);
    // bus stall, then eret beats jump during the stall
    vecs[15] = v(5'b00000, 0, 0, 0,0,32'h0,1, 1,32'h80003000, 1,32'h80002000,32'h55555555,0);
    vecs[16] = v(5'b01001, 32'hbfc00500, 32'h90000000, 0,0,32'h0,1, 1,32'h80003000, 0,0,0,0);
    // jump in handshake cycle overrides pc+4, to a misaligned target
    vecs[17] = v(5'b00001, 32'h80000002, 0, 1,0,32'h0,1, 1,32'hbfc00500, 0,0,0,0);
    vecs[18] = v(5'b00000, 0, 0, 0,1,32'h66666666,1, 0,32'h80000002, 0,0,0,0);
    vecs[19] = v(5'b00000, 0, 0, 0,0,32'h0,1, !A,32'h80000002, 1,32'hbfc00500,32'h66666666,0);
    vecs[20] = v(5'b00000, 0, 0, 1,0,32'h0,0, !A,32'h80000002, A,32'h80000002,32'h0,A);

    apply(v(5'b00000, 0, 0, 0,0,32'h0,0, 0,0,0,0,0,0));
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset f_pc", f_pc, 32'h0);
    chk("reset f_instr", f_instr, 32'h0);

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      apply(vecs[i]);
      #1;
      check_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Reset while a request is outstanding returns to a fresh fetch.
    @(negedge clk);
    apply(v(5'b00000, 0, 0, 0,0,32'h0,0, 0,0,0,0,0,0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    apply(v(5'b00000, 0, 0, 0,0,32'h0,1, 0,0,0,0,0,0));
    #1;
    check_vec("rst_mid", v(0,0,0,0,0,0,0, 1,32'hbfc00000, 0,0,0,0));

    // pc wrap-around: 0xfffffffc + 4 = 0.
    apply(v(5'b00001, 32'hfffffffc, 0, 0,0,32'h0,1, 0,0,0,0,0,0));
    @(negedge clk);
    apply(v(5'b00000, 0, 0, 1,0,32'h0,1, 0,0,0,0,0,0));
    #1;
    check_vec("wrap_req", v(0,0,0,0,0,0,0, 1,32'hfffffffc, 0,0,0,0));
    @(negedge clk);
    apply(v(5'b00000, 0, 0, 0,1,32'h77777777,1, 0,0,0,0,0,0));
    #1;
    check_vec("wrap_resp", v(0,0,0,0,0,0,0, 0,0, 0,0,0,0));
    @(negedge clk);
    apply(v(5'b00000, 0, 0, 1,0,32'h0,1, 0,0,0,0,0,0));
    #1;
    check_vec("wrap_next", v(0,0,0,0,0,0,0, 1,32'h00000000, 1,32'hfffffffc,32'h77777777,0));

    // Flush coinciding with the response: data dropped, fetch at target.
    @(negedge clk);
    apply(v(5'b10000, 32'hbfc00380, 0, 0,1,32'haaaaaaaa,1, 0,0,0,0,0,0));
    #1;
    check_vec("flush_resp", v(0,0,0,0,0,0,0, 0,0, 0,0,0,0));
    @(negedge clk);
    apply(v(5'b00000, 0, 0, 0,0,32'h0,1, 0,0,0,0,0,0));
    #1;
    check_vec("flush_after", v(0,0,0,0,0,0,0, 1,32'hbfc00380, 0,0,0,0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
